// File: rtl/reg_native_if_pkg.sv
// rtl/reg_native_if_pkg.sv - shared state, response codes and native request type for reg_axi4lite2native_if
package reg_native_if_pkg;

    // Widest native address/data the request record can carry.
    localparam int NATIVE_ADDR_MAX = 64;
    localparam int NATIVE_DATA_MAX = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_WR_RESP,
        S_RD_RESP
`ifdef REG_AXI4LITE2NATIVE_IF_TIMEOUT_EN
        ,
        S_FLUSH
`endif
    } state_e;

    typedef struct packed {
        logic                       wr_en;
        logic                       rd_en;
        logic [NATIVE_ADDR_MAX-1:0] addr;
        logic [NATIVE_DATA_MAX-1:0] wr_data;
    } native_req_t;

endpackage

// File: rtl/reg_axi_chan_hold.sv
// rtl/reg_axi_chan_hold.sv - one-entry valid/ready holding register with registered ready
module reg_axi_chan_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             full,
    output logic [WIDTH-1:0] data,
    input  logic             take
);

    logic load;
    logic full_next;

    assign load = in_valid && in_ready;

    // Load and take never coincide: load needs the entry empty, take needs it full.
    always_comb begin
        full_next = full;
        if (load) begin
            full_next = 1'b1;
        end else if (take) begin
            full_next = 1'b0;
        end
    end

    // Entry storage; ready is registered from the next fullness so it never follows VALID.
    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= 1'b0;
            in_ready <= 1'b0;
            data     <= '0;
        end else begin
            full     <= full_next;
            in_ready <= !full_next;
            if (load) begin
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/reg_axi4lite2native_if.sv
// rtl/reg_axi4lite2native_if.sv - AXI4-Lite slave to single-outstanding native request front end; optional ack timeout under REG_AXI4LITE2NATIVE_IF_TIMEOUT_EN
module reg_axi4lite2native_if
    import reg_native_if_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32
`ifdef REG_AXI4LITE2NATIVE_IF_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [1:0]              BRESP,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    req_vld,
    output logic                    wr_en,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    ack_vld,
    input  logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                             aw_full;
    logic                             w_full;
    logic                             ar_full;
    logic [ADDR_WIDTH-1:0]            aw_addr;
    logic [ADDR_WIDTH-1:0]            ar_addr;
    logic [DATA_WIDTH+STRB_WIDTH-1:0] w_payload;
    logic                             take_wr;
    logic                             take_rd;
    logic                             wr_ready;
    logic                             rd_ready;
    logic                             strb_ok;
    logic                             ack_ok;
    logic                             timeout;
    logic                             rr_rd_first;
    state_e                           state;
    state_e                           state_next;
    state_e                           resp_exit;
    native_req_t                      native_q;

    reg_axi_chan_hold #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (AWVALID),
        .in_ready (AWREADY),
        .in_data  (AWADDR),
        .full     (aw_full),
        .data     (aw_addr),
        .take     (take_wr)
    );

    reg_axi_chan_hold #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_w_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (WVALID),
        .in_ready (WREADY),
        .in_data  ({WSTRB, WDATA}),
        .full     (w_full),
        .data     (w_payload),
        .take     (take_wr)
    );

    reg_axi_chan_hold #(.WIDTH(ADDR_WIDTH)) u_ar_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (ARVALID),
        .in_ready (ARREADY),
        .in_data  (ARADDR),
        .full     (ar_full),
        .data     (ar_addr),
        .take     (take_rd)
    );

    assign wr_ready = aw_full && w_full;
    assign rd_ready = ar_full;
    assign strb_ok  = &w_payload[DATA_WIDTH +: STRB_WIDTH];
    // An ack coinciding with our own request pulse cannot belong to it.
    assign ack_ok   = (state == S_WAIT_ACK) && ack_vld && !req_vld;

    assign wr_en   = native_q.wr_en;
    assign rd_en   = native_q.rd_en;
    assign addr    = native_q.addr[ADDR_WIDTH-1:0];
    assign wr_data = native_q.wr_data[DATA_WIDTH-1:0];

`ifdef REG_AXI4LITE2NATIVE_IF_TIMEOUT_EN
    localparam int CNT_RAW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_WIDTH = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

    logic [CNT_WIDTH-1:0] cnt;
    logic                 timed_out;

    assign timeout   = (state == S_WAIT_ACK) && !ack_ok && (cnt == CNT_WIDTH'(TIMEOUT_CYCLES));
    // A timed-out request still owes us one late ack, which must be swallowed.
    assign resp_exit = timed_out ? S_FLUSH : S_IDLE;

    // Ack wait counter (zero on the req_vld cycle) and the owed-stale-ack flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            timed_out <= 1'b0;
        end else begin
            if (take_rd || take_wr) begin
                cnt <= '0;
            end else if (state == S_WAIT_ACK) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
            if (timeout) begin
                timed_out <= 1'b1;
            end else if ((state == S_FLUSH) && ack_vld) begin
                timed_out <= 1'b0;
            end
        end
    end
`else
    assign timeout   = 1'b0;
    assign resp_exit = S_IDLE;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and arbitration: round-robin between a complete write and a read.
    always_comb begin
        state_next = state;
        take_wr    = 1'b0;
        take_rd    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rd_ready && (!wr_ready || rr_rd_first)) begin
                    take_rd    = 1'b1;
                    state_next = S_WAIT_ACK;
                end else if (wr_ready) begin
                    take_wr    = 1'b1;
                    state_next = strb_ok ? S_WAIT_ACK : S_WR_RESP;
                end
            end
            S_WAIT_ACK: begin
                if (ack_ok || timeout) begin
                    state_next = native_q.wr_en ? S_WR_RESP : S_RD_RESP;
                end
            end
            S_WR_RESP: begin
                if (BREADY) begin
                    state_next = resp_exit;
                end
            end
            S_RD_RESP: begin
                if (RREADY) begin
                    state_next = resp_exit;
                end
            end
`ifdef REG_AXI4LITE2NATIVE_IF_TIMEOUT_EN
            S_FLUSH: begin
                if (ack_vld) begin
                    state_next = S_IDLE;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Native request issue, AXI responses and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_vld     <= 1'b0;
            native_q    <= '0;
            BVALID      <= 1'b0;
            BRESP       <= AXI_RESP_OKAY;
            RVALID      <= 1'b0;
            RDATA       <= '0;
            RRESP       <= AXI_RESP_OKAY;
            rr_rd_first <= 1'b1;
        end else begin
            req_vld <= 1'b0;
            if (take_rd || take_wr) begin
                rr_rd_first <= !rr_rd_first;
            end
            if (take_rd) begin
                req_vld  <= 1'b1;
                native_q <= '{wr_en: 1'b0, rd_en: 1'b1,
                              addr: NATIVE_ADDR_MAX'(ar_addr), wr_data: '0};
            end
            if (take_wr && strb_ok) begin
                req_vld  <= 1'b1;
                native_q <= '{wr_en: 1'b1, rd_en: 1'b0,
                              addr: NATIVE_ADDR_MAX'(aw_addr),
                              wr_data: NATIVE_DATA_MAX'(w_payload[DATA_WIDTH-1:0])};
            end
            if (take_wr && !strb_ok) begin
                BVALID <= 1'b1;
                BRESP  <= AXI_RESP_SLVERR;
            end
            if (ack_ok || timeout) begin
                if (native_q.wr_en) begin
                    BVALID <= 1'b1;
                    BRESP  <= ack_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                end else begin
                    RVALID <= 1'b1;
                    RRESP  <= ack_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                    RDATA  <= ack_ok ? rd_data : '0;
                end
            end
            if (BVALID && BREADY) begin
                BVALID <= 1'b0;
            end
            if (RVALID && RREADY) begin
                RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_axi4lite2native_if.sv
// tb/tb_reg_axi4lite2native_if.sv - scoreboard bench for reg_axi4lite2native_if
module tb_reg_axi4lite2native_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        AWVALID = 1'b0, WVALID = 1'b0, ARVALID = 1'b0;
    logic        AWREADY, WREADY, ARREADY;
    logic [63:0] AWADDR = '0, ARADDR = '0;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        BVALID, RVALID;
    logic        BREADY = 1'b1, RREADY = 1'b1;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;
    logic        req_vld, wr_en, rd_en;
    logic [63:0] addr;
    logic [31:0] wr_data;
    logic        ack_auto = 1'b0, ack_man = 1'b0;
    logic        ack_vld;
    logic [31:0] rd_data = 32'h1234_5678;

    assign ack_vld = ack_auto | ack_man;

    typedef struct { logic wr; logic [63:0] a; logic [31:0] d; } req_t;
    typedef struct { logic [31:0] d; logic [1:0] r; } rresp_t;

    req_t       exp_req[$];
    logic [1:0] exp_b[$];
    rresp_t     exp_r[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ack_cnt     = 0;
    int ack_delay   = 3;
    bit auto_ack    = 1'b1;

    reg_axi4lite2native_if #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (32)
`ifdef REG_AXI4LITE2NATIVE_IF_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clk (clk), .rst (rst),
        .AWVALID (AWVALID), .AWREADY (AWREADY), .AWADDR (AWADDR),
        .WVALID (WVALID), .WREADY (WREADY), .WDATA (WDATA), .WSTRB (WSTRB),
        .BVALID (BVALID), .BREADY (BREADY), .BRESP (BRESP),
        .ARVALID (ARVALID), .ARREADY (ARREADY), .ARADDR (ARADDR),
        .RVALID (RVALID), .RREADY (RREADY), .RDATA (RDATA), .RRESP (RRESP),
        .req_vld (req_vld), .wr_en (wr_en), .rd_en (rd_en), .addr (addr),
        .wr_data (wr_data), .ack_vld (ack_vld), .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Native responder: ack ack_delay cycles after each req_vld pulse.
    always @(posedge clk) begin
        #1;
        ack_auto = 1'b0;
        if (ack_cnt > 0) begin
            ack_cnt = ack_cnt - 1;
            if (ack_cnt == 0) ack_auto = 1'b1;
        end else if (req_vld && auto_ack) begin
            ack_cnt = ack_delay;
        end
    end

    // Monitor: compare every native request and AXI response against the queues.
    always @(negedge clk) begin : monitor
        req_t   e;
        rresp_t er;
        if (!rst) begin
            if (req_vld) begin
                if (exp_req.size() == 0) check("unexpected_req", 1, 0);
                else begin
                    e = exp_req.pop_front();
                    check("req_wr_en", wr_en, e.wr);
                    check("req_rd_en", rd_en, !e.wr);
                    check("req_addr", addr, e.a);
                    if (e.wr) check("req_wr_data", wr_data, e.d);
                end
            end
            if (BVALID && BREADY) begin
                if (exp_b.size() == 0) check("unexpected_b", 1, 0);
                else check("bresp", BRESP, exp_b.pop_front());
            end
            if (RVALID && RREADY) begin
                if (exp_r.size() == 0) check("unexpected_r", 1, 0);
                else begin
                    er = exp_r.pop_front();
                    check("rdata", RDATA, er.d);
                    check("rresp", RRESP, er.r);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_for(input int which, input string name, output int c);
        logic s;
        c = -1;
        for (int i = 0; i < 300; i++) begin
            case (which)
                0:       s = req_vld;
                1:       s = BVALID;
                default: s = RVALID;
            endcase
            if (s) begin
                c = cyc;
                return;
            end
            step(1);
        end
        check({"timeout_", name}, 1, 0);
    endtask

    // Present the chosen channels together; hs is the cycle of the last handshake.
    task automatic axi_send(input bit do_aw, input bit do_w, input bit do_ar,
                            input logic [63:0] wa, input logic [31:0] d,
                            input logic [3:0] s, input logic [63:0] ra, output int hs);
        bit aw_hs, w_hs, ar_hs;
        AWVALID = do_aw; AWADDR = wa;
        WVALID  = do_w;  WDATA  = d; WSTRB = s;
        ARVALID = do_ar; ARADDR = ra;
        hs = -1;
        for (int i = 0; i < 100 && (AWVALID || WVALID || ARVALID); i++) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            ar_hs = ARVALID && ARREADY;
            if (aw_hs || w_hs || ar_hs) hs = cyc;
            step(1);
            if (aw_hs) AWVALID = 1'b0;
            if (w_hs)  WVALID  = 1'b0;
            if (ar_hs) ARVALID = 1'b0;
        end
        if (AWVALID || WVALID || ARVALID) begin
            check("axi_handshake_timeout", 1, 0);
            AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int hs, c, b0, s_cyc;
        bit seen;

        // Reset state
        step(3);
        check("rst_req_vld", req_vld, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_addr", addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_readies", {AWREADY, WREADY, ARREADY}, 0);
        rst = 1'b0;
        step(1);

        // Same-cycle AW+W, ack 3 cycles after req_vld
        exp_req.push_back('{wr: 1'b1, a: 64'h40, d: 32'hDEAD_BEEF});
        exp_b.push_back(2'b00);
        axi_send(1, 1, 0, 64'h40, 32'hDEAD_BEEF, 4'hF, 0, hs);
        wait_for(0, "t1_req", c);
        check("t1_req_latency", c - hs, 2);
        wait_for(1, "t1_bvalid", b0);
        check("t1_bvalid_after_ack", b0 - c, 4);
        step(3);

        // Partial strobe: no native request, SLVERR
        exp_b.push_back(2'b10);
        axi_send(1, 1, 0, 64'h44, 32'h1111_2222, 4'h3, 0, hs);
        wait_for(1, "t4_bvalid", b0);
        step(3);

        // W leads AW by 5 cycles; BREADY low for 4 cycles
        BREADY = 1'b0;
        exp_req.push_back('{wr: 1'b1, a: 64'h80, d: 32'hCAFE_F00D});
        exp_b.push_back(2'b00);
        axi_send(0, 1, 0, 0, 32'hCAFE_F00D, 4'hF, 0, hs);
        seen = 1'b0;
        repeat (5) begin
            seen |= req_vld;
            step(1);
        end
        check("t2_no_req_before_aw", seen, 0);
        axi_send(1, 0, 0, 64'h80, 0, 4'hF, 0, hs);
        wait_for(0, "t2_req", c);
        check("t2_req_latency", c - hs, 2);
        wait_for(1, "t2_bvalid", b0);
        for (int i = 0; i < 4; i++) begin
            check("t2_bvalid_held", {BVALID, BRESP}, {1'b1, 2'b00});
            step(1);
        end
        BREADY = 1'b1;
        step(1);
        check("t2_bvalid_drop", BVALID, 0);
        step(2);

        // Read and write pending together after reset: read first
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        exp_req.push_back('{wr: 1'b0, a: 64'h100, d: 32'h0});
        exp_req.push_back('{wr: 1'b1, a: 64'h200, d: 32'h0BAD_F00D});
        exp_r.push_back('{d: 32'h1234_5678, r: 2'b00});
        exp_b.push_back(2'b00);
        axi_send(1, 1, 1, 64'h200, 32'h0BAD_F00D, 4'hF, 64'h100, hs);
        wait_for(2, "t3_rvalid", c);
        wait_for(1, "t3_bvalid", c);
        step(3);

        // Reset while waiting for ack
        auto_ack = 1'b0;
        exp_req.push_back('{wr: 1'b0, a: 64'h300, d: 32'h0});
        axi_send(0, 0, 1, 0, 0, 4'hF, 64'h300, hs);
        wait_for(0, "t5_req", c);
        step(1);
        rst = 1'b1;
        step(1);
        check("t5_rst_outputs", {req_vld, wr_en, rd_en, BVALID, RVALID, addr, wr_data}, 0);
        rst = 1'b0;
        step(3);
        ack_man = 1'b1;
        step(1);
        ack_man = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            seen |= BVALID | RVALID | req_vld;
            step(1);
        end
        check("t5_stray_ack_ignored", seen, 0);
        auto_ack = 1'b1;
        exp_req.push_back('{wr: 1'b0, a: 64'h304, d: 32'h0});
        exp_r.push_back('{d: 32'h1234_5678, r: 2'b00});
        axi_send(0, 0, 1, 0, 0, 4'hF, 64'h304, hs);
        wait_for(2, "t5_rvalid", c);
        step(3);

`ifdef REG_AXI4LITE2NATIVE_IF_TIMEOUT_EN
        // Timeout, then a stale ack must be swallowed before the next request
        auto_ack = 1'b0;
        exp_req.push_back('{wr: 1'b0, a: 64'h400, d: 32'h0});
        exp_r.push_back('{d: 32'h0, r: 2'b10});
        axi_send(0, 0, 1, 0, 0, 4'hF, 64'h400, hs);
        wait_for(0, "t6_req", c);
        wait_for(2, "t6_rvalid", b0);
        check("t6_timeout_latency", b0 - c, 9);
        step(1);
        exp_req.push_back('{wr: 1'b0, a: 64'h404, d: 32'h0});
        exp_r.push_back('{d: 32'h1234_5678, r: 2'b00});
        axi_send(0, 0, 1, 0, 0, 4'hF, 64'h404, hs);
        seen = 1'b0;
        repeat (20) begin
            seen |= req_vld;
            step(1);
        end
        check("t6_no_req_before_stale_ack", seen, 0);
        ack_man = 1'b1;
        s_cyc = cyc;
        step(1);
        ack_man = 1'b0;
        ack_delay = 2;
        auto_ack = 1'b1;
        wait_for(0, "t6_req2", c);
        check("t6_req_after_stale_ack", c > s_cyc, 1);
        wait_for(2, "t6_rvalid2", c);
        step(3);
`endif

        step(5);
        check("exp_req_drained", exp_req.size(), 0);
        check("exp_b_drained", exp_b.size(), 0);
        check("exp_r_drained", exp_r.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
